act_requant_buffer: RTL and testbench

- Downstream neighbour of the hidden-layer engine.
- Consumes the post-ReLU activation stream (ACC_W wide, valid-only, no backpressure) and requantizes each value to DATA_W with round-half-up and saturation.
- Stores one hidden vector (N_HIDDEN entries) per bank in a ping-pong buffer.
- Replays each completed vector on a valid/ready stream with index and last markers, as the input of the future output layer.

---
 rtl/act_requant_buffer_if.sv | 27 ++
 rtl/act_requant_buffer.sv | 229 ++++++++++++++++++++++
 tb/tb_act_requant_buffer.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/act_requant_buffer_if.sv
// act_requant_buffer_if
// Output stream of the requantize/ping-pong buffer: one hidden vector
// replayed sample by sample with its position and an end-of-vector marker.
//
// Signals:
//   data   signed requantized sample (DATA_W)
//   valid  data/index/last are valid
//   ready  consumer accepts when valid && ready
//   index  position of data within the vector (IDX_W)
//   last   high together with the final index of the vector
//
// Modports:
//   master  the buffer (drives data/valid/index/last, reads ready)
//   slave   the consumer (reads data/valid/index/last, drives ready)
interface act_requant_buffer_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 6
) ();
    logic signed [DATA_W-1:0] data;
    logic                     valid;
    logic                     ready;
    logic [IDX_W-1:0]         index;
    logic                     last;

    modport master (output data, output valid, input ready, output index, output last);
    modport slave  (input data, input valid, output ready, input index, input last);
endinterface

// File: rtl/act_requant_buffer.sv
// act_requant_buffer
// Takes the post-ReLU activation stream of the hidden-layer engine,
// requantizes every sample to DATA_W (round-half-up, then saturate) and
// collects one hidden vector of N_HIDDEN samples per bank of a two-bank
// ping-pong buffer. Completed vectors are replayed in arrival order on a
// valid/ready stream. A vector that arrives while its target bank is still
// occupied is dropped whole and flagged on overflow_err.
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   in_data       signed activation sample (ACC_W), valid-only, never stalled
//   in_valid      in_data present this cycle
//   cfg_shift     right-shift amount, sampled with the first sample of a vector
//   m             output stream (act_requant_buffer_if.master)
//   overflow_err  sticky, a whole vector was dropped
//   sat_count     (RQ_SAT_COUNT_EN only) saturating count of clipped samples
//
// Build option:
//   RQ_SAT_COUNT_EN  adds the sat_count port and its counter
module act_requant_buffer #(
    parameter int DATA_W   = 16,
    parameter int N_IN     = 128,
    parameter int ACC_W    = 2*DATA_W + $clog2(N_IN),
    parameter int N_HIDDEN = 64,
    parameter int IDX_W    = $clog2(N_HIDDEN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [ACC_W-1:0] in_data,
    input  logic                    in_valid,
    input  logic [5:0]              cfg_shift,
    act_requant_buffer_if.master    m,
    output logic                    overflow_err
`ifdef RQ_SAT_COUNT_EN
    ,
    output logic [15:0]             sat_count
`endif
);
    localparam logic [0:0]            R_IDLE    = 1'b0;
    localparam logic [0:0]            R_STREAM  = 1'b1;
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(N_HIDDEN-1);
    localparam logic [IDX_W-1:0]      FIRST_IDX = '0;
    localparam logic [5:0]            MAX_SHIFT = 6'(ACC_W-1);
    localparam logic [ACC_W:0]        ONE       = (ACC_W+1)'(1);
    localparam logic signed [ACC_W:0] SAT_MAX   = (ACC_W+1)'((1 << (DATA_W-1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN   = ~SAT_MAX;

    // input-side frame tracking
    logic [IDX_W-1:0] wr_cnt;
    logic             wr_bank;
    logic             drop_mode;
    logic [5:0]       shift_q;
    logic [1:0]       full;

    // S1 pipeline register (requantized sample plus its destination)
    logic                     s1_valid;
    logic                     s1_bank;
    logic                     s1_last;
    logic [IDX_W-1:0]         s1_idx;
    logic signed [DATA_W-1:0] s1_data;

    // read side
    logic [0:0]               rd_state;
    logic                     rd_bank;
    logic                     m_valid_q;
    logic                     m_last_q;
    logic [IDX_W-1:0]         m_index_q;
    logic [IDX_W-1:0]         rd_next;
    logic signed [DATA_W-1:0] m_data_q;

    logic signed [DATA_W-1:0] mem [2][N_HIDDEN];

    logic                     drop_now;
    logic                     accept;
    logic [5:0]               shift_now;
    logic signed [ACC_W:0]    in_ext;
    logic signed [ACC_W:0]    round_add;
    logic signed [ACC_W:0]    sum;
    logic signed [ACC_W:0]    shifted;
    logic                     sat_hi;
    logic                     sat_lo;
    logic signed [DATA_W-1:0] rq_data;

    // The first sample of a vector decides both the shift and whether the
    // whole vector is dropped, so those come straight from the live inputs
    // at wr_cnt==0 and from the latched copies for the rest of the vector.
    // Using the registered full flags means a bank freed by the reader in
    // this very cycle still counts as occupied.
    always_comb begin
        drop_now  = (wr_cnt == FIRST_IDX) ? full[wr_bank] : drop_mode;
        accept    = in_valid && !drop_now;
        shift_now = shift_q;
        if (wr_cnt == FIRST_IDX) begin
            shift_now = (cfg_shift > MAX_SHIFT) ? MAX_SHIFT : cfg_shift;
        end
        in_ext    = {in_data[ACC_W-1], in_data};
        round_add = '0;
        if (shift_now != 6'd0) begin
            round_add = ONE << (shift_now - 6'd1);
        end
        sum     = in_ext + round_add;
        shifted = sum >>> shift_now;
        sat_hi  = shifted > SAT_MAX;
        sat_lo  = shifted < SAT_MIN;
        if (sat_hi) begin
            rq_data = SAT_MAX[DATA_W-1:0];
        end else if (sat_lo) begin
            rq_data = SAT_MIN[DATA_W-1:0];
        end else begin
            rq_data = shifted[DATA_W-1:0];
        end
    end

    // A dropped vector still walks wr_cnt through N_HIDDEN samples so the
    // next vector is recognised, but it leaves wr_bank where it was.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt       <= '0;
            wr_bank      <= 1'b0;
            drop_mode    <= 1'b0;
            shift_q      <= '0;
            overflow_err <= 1'b0;
        end else if (in_valid) begin
            if (wr_cnt == FIRST_IDX) begin
                shift_q   <= shift_now;
                drop_mode <= full[wr_bank];
                if (full[wr_bank]) begin
                    overflow_err <= 1'b1;
                end
            end
            if (wr_cnt == LAST_IDX) begin
                wr_cnt <= '0;
                if (!drop_now) begin
                    wr_bank <= ~wr_bank;
                end
            end else begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_bank  <= 1'b0;
            s1_last  <= 1'b0;
            s1_idx   <= '0;
            s1_data  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_bank <= wr_bank;
                s1_idx  <= wr_cnt;
                s1_last <= (wr_cnt == LAST_IDX);
                s1_data <= rq_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s1_valid && !rst) begin
            mem[s1_bank][s1_idx] <= s1_data;
        end
    end

    assign rd_next = m_index_q + 1'b1;

    // The bank being written is never the one being streamed (a vector
    // only lands in a free bank), so setting and clearing full bits in the
    // same cycle never touch the same bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            full      <= '0;
            rd_state  <= R_IDLE;
            rd_bank   <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_index_q <= '0;
            m_data_q  <= '0;
        end else begin
            if (s1_valid && s1_last) begin
                full[s1_bank] <= 1'b1;
            end
            case (rd_state)
                R_IDLE: begin
                    if (full[rd_bank]) begin
                        rd_state  <= R_STREAM;
                        m_valid_q <= 1'b1;
                        m_data_q  <= mem[rd_bank][FIRST_IDX];
                        m_index_q <= FIRST_IDX;
                        m_last_q  <= 1'b0;
                    end
                end
                R_STREAM: begin
                    if (m.ready) begin
                        if (m_last_q) begin
                            full[rd_bank] <= 1'b0;
                            rd_bank       <= ~rd_bank;
                            rd_state      <= R_IDLE;
                            m_valid_q     <= 1'b0;
                        end else begin
                            m_data_q  <= mem[rd_bank][rd_next];
                            m_index_q <= rd_next;
                            m_last_q  <= (rd_next == LAST_IDX);
                        end
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    assign m.data  = m_data_q;
    assign m.valid = m_valid_q;
    assign m.index = m_index_q;
    assign m.last  = m_last_q;

`ifdef RQ_SAT_COUNT_EN
    // Only samples that are actually stored are counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_count <= '0;
        end else if (accept && (sat_hi || sat_lo) && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_act_requant_buffer.sv
// tb_act_requant_buffer
// Directed bench for act_requant_buffer with N_HIDDEN=4, DATA_W=16.
// Requantization cases come from a vector table; backpressure, overflow,
// mid-frame reset and the optional saturation counter are hand sequences.
module tb_act_requant_buffer;
    localparam int DATA_W   = 16;
    localparam int N_IN     = 128;
    localparam int ACC_W    = 2*DATA_W + $clog2(N_IN);
    localparam int N_HIDDEN = 4;
    localparam int IDX_W    = 2;
    localparam int NV       = 5;

    typedef logic signed [ACC_W-1:0]  sample_t;
    typedef logic signed [DATA_W-1:0] result_t;
    typedef sample_t frame_t [N_HIDDEN];

    typedef struct {
        logic [5:0] shift;
        sample_t    din  [N_HIDDEN];
        result_t    dout [N_HIDDEN];
    } vec_t;

    typedef struct {
        result_t          data;
        logic [IDX_W-1:0] index;
        logic             last;
        int               cyc;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    sample_t    in_data = '0;
    logic       in_valid = 1'b0;
    logic [5:0] cfg_shift = '0;
    logic       overflow_err;
`ifdef RQ_SAT_COUNT_EN
    logic [15:0] sat_count;
`endif

    int    n_compared = 0;
    int    n_mismatched = 0;
    int    cyc = 0;
    int    t_last = 0;
    int    low_run = 0;
    logic  ready_level = 1'b1;
    logic  toggle_en = 1'b0;
    logic  bubble_en = 1'b0;
    logic  after_last = 1'b0;
    logic  probe_ovf = 1'b0;
    beat_t cap_q[$];
    beat_t exp_q[$];
    vec_t  vecs [NV];

    act_requant_buffer_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) m_if ();

    act_requant_buffer #(
        .DATA_W(DATA_W),
        .N_IN(N_IN),
        .N_HIDDEN(N_HIDDEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .cfg_shift(cfg_shift),
        .m(m_if),
        .overflow_err(overflow_err)
`ifdef RQ_SAT_COUNT_EN
        ,
        .sat_count(sat_count)
`endif
    );

    always #5 clk = ~clk;

    // cycle counter, bumped on every rising edge
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // consumer ready: either a fixed level or a per-cycle toggle
    initial begin
        m_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_if.ready = toggle_en ? ~m_if.ready : ready_level;
        end
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, expected);
        end
    endtask

    // monitor: captures handshakes, checks stalled beats against the next
    // expected beat and measures the idle gap between vectors
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                after_last = 1'b0;
                low_run = 0;
            end else if (m_if.valid) begin
                if (bubble_en && after_last) begin
                    checkOutput("bubble_len", low_run, 1);
                end
                after_last = 1'b0;
                low_run = 0;
                if (m_if.ready) begin
                    cap_q.push_back('{data: m_if.data, index: m_if.index, last: m_if.last, cyc: cyc});
                    if (m_if.last) begin
                        after_last = 1'b1;
                    end
                end else if (cap_q.size() < exp_q.size()) begin
                    checkOutput("stall_data", m_if.data, exp_q[cap_q.size()].data);
                    checkOutput("stall_index", m_if.index, exp_q[cap_q.size()].index);
                    checkOutput("stall_last", m_if.last, exp_q[cap_q.size()].last);
                end
            end else begin
                low_run++;
            end
        end
    end

    task automatic applyReset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cap_q.delete();
        exp_q.delete();
    endtask

    // drives one vector back-to-back; cfg_shift is scrambled after the first
    // sample so only the value latched at vector start may matter
    task automatic applyStimulus(input logic [5:0] shift, input frame_t din);
        for (int i = 0; i < N_HIDDEN; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                cfg_shift = shift;
            end else if (i == 1) begin
                cfg_shift = ~shift;
                if (probe_ovf) begin
                    checkOutput("ovf_first_sample", overflow_err, 1);
                end
            end
            in_valid = 1'b1;
            in_data = din[i];
            t_last = cyc;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data = '0;
    endtask

    task automatic makeFrame(input int base, output frame_t f);
        for (int i = 0; i < N_HIDDEN; i++) begin
            f[i] = sample_t'(base + i);
        end
    endtask

    task automatic pushExpected(input int base);
        for (int i = 0; i < N_HIDDEN; i++) begin
            exp_q.push_back('{data: result_t'(base + i), index: IDX_W'(i), last: (i == N_HIDDEN-1), cyc: 0});
        end
    endtask

    task automatic waitBeats(input int n, input int budget);
        int k = 0;
        while (cap_q.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (cap_q.size() < n) begin
            checkOutput("beat_timeout", cap_q.size(), n);
        end
    endtask

    task automatic compareBeats();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < cap_q.size()) begin
                checkOutput("seq_data", cap_q[i].data, exp_q[i].data);
                checkOutput("seq_index", cap_q[i].index, exp_q[i].index);
                checkOutput("seq_last", cap_q[i].last, exp_q[i].last);
            end
        end
        checkOutput("seq_count", cap_q.size(), exp_q.size());
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual running, required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        frame_t f;

        vecs[0].shift = 6'd0;
        vecs[0].din   = '{1, 2, 3, 4};
        vecs[0].dout  = '{1, 2, 3, 4};
        vecs[1].shift = 6'd4;
        vecs[1].din   = '{24, 23, 1048576, -24};
        vecs[1].dout  = '{2, 1, 32767, -1};
        vecs[2].shift = 6'd0;
        vecs[2].din   = '{-40000, 40000, 32767, -32768};
        vecs[2].dout  = '{-32768, 32767, 32767, -32768};
        vecs[3].shift = 6'd63;
        vecs[3].din   = '{sample_t'(5), sample_t'(64'sd274877906943),
                          sample_t'(-64'sd274877906944), sample_t'(64'sd137438953472)};
        vecs[3].dout  = '{0, 1, -1, 1};
        vecs[4].shift = 6'd1;
        vecs[4].din   = '{3, -3, 65535, -65537};
        vecs[4].dout  = '{2, -1, 32767, -32768};

        applyReset();
        checkOutput("reset_valid", m_if.valid, 0);
        checkOutput("reset_data", m_if.data, 0);
        checkOutput("reset_index", m_if.index, 0);
        checkOutput("reset_last", m_if.last, 0);
        checkOutput("reset_overflow", overflow_err, 0);

        // requantization table, read side idle before each vector
        for (int v = 0; v < NV; v++) begin
            cap_q.delete();
            applyStimulus(vecs[v].shift, vecs[v].din);
            waitBeats(N_HIDDEN, 40);
            for (int i = 0; i < N_HIDDEN; i++) begin
                if (i < cap_q.size()) begin
                    checkOutput("vec_data", cap_q[i].data, vecs[v].dout[i]);
                    checkOutput("vec_index", cap_q[i].index, i);
                    checkOutput("vec_last", cap_q[i].last, (i == N_HIDDEN-1) ? 1 : 0);
                end
            end
            if (cap_q.size() > 0) begin
                checkOutput("vec_latency", cap_q[0].cyc - t_last, 3);
            end
            repeat (3) @(posedge clk);
        end
        $display("[TB] requantization table done");

        // backpressure: four vectors with ready toggling every cycle
        applyReset();
        bubble_en = 1'b1;
        toggle_en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            pushExpected(100 * k);
        end
        makeFrame(100, f);
        applyStimulus(6'd0, f);
        makeFrame(200, f);
        applyStimulus(6'd0, f);
        waitBeats(4, 100);
        repeat (1) @(posedge clk);
        makeFrame(300, f);
        applyStimulus(6'd0, f);
        waitBeats(8, 100);
        repeat (1) @(posedge clk);
        makeFrame(400, f);
        applyStimulus(6'd0, f);
        waitBeats(16, 200);
        repeat (10) @(posedge clk);
        compareBeats();
        bubble_en = 1'b0;
        toggle_en = 1'b0;
        checkOutput("bp_no_overflow", overflow_err, 0);
        $display("[TB] backpressure sequence done");

        // overflow: third vector arrives while both banks are occupied
        applyReset();
        ready_level = 1'b0;
        @(posedge clk);
        #1;
        pushExpected(10);
        pushExpected(20);
        makeFrame(10, f);
        applyStimulus(6'd0, f);
        makeFrame(20, f);
        applyStimulus(6'd0, f);
        checkOutput("ovf_before_c", overflow_err, 0);
        probe_ovf = 1'b1;
        makeFrame(30, f);
        applyStimulus(6'd0, f);
        probe_ovf = 1'b0;
        checkOutput("ovf_after_c", overflow_err, 1);
        ready_level = 1'b1;
        waitBeats(8, 100);
        repeat (20) @(posedge clk);
        compareBeats();
        checkOutput("ovf_sticky", overflow_err, 1);
        applyReset();
        checkOutput("ovf_cleared", overflow_err, 0);
        $display("[TB] overflow sequence done");

        // reset in the middle of a vector
        cfg_shift = 6'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data = 5;
        @(posedge clk);
        #1;
        in_data = 6;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_valid_during", m_if.valid, 0);
        checkOutput("midrst_data_during", m_if.data, 0);
        checkOutput("midrst_index_during", m_if.index, 0);
        checkOutput("midrst_last_during", m_if.last, 0);
        rst = 1'b0;
        cap_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        checkOutput("midrst_valid_after", m_if.valid, 0);
        checkOutput("midrst_overflow_after", overflow_err, 0);
        for (int i = 0; i < N_HIDDEN; i++) begin
            exp_q.push_back('{data: result_t'(9 - i), index: IDX_W'(i), last: (i == N_HIDDEN-1), cyc: 0});
        end
        f = '{9, 8, 7, 6};
        applyStimulus(6'd0, f);
        waitBeats(4, 40);
        repeat (5) @(posedge clk);
        compareBeats();
        $display("[TB] mid-frame reset sequence done");

`ifdef RQ_SAT_COUNT_EN
        applyReset();
        checkOutput("sat_count_reset", sat_count, 0);
        f = '{40000, 1, 70000, -2};
        applyStimulus(6'd0, f);
        checkOutput("sat_count_frame", sat_count, 2);
        applyReset();
        checkOutput("sat_count_cleared", sat_count, 0);
        $display("[TB] saturation counter sequence done");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
